mr1_ibus_bridge: RTL

- Instruction-fetch bridge directly downstream of the MR1 fetch port (instr_req_* / instr_rsp_*); converts it to a memory-side command/response bus with bounded outstanding requests.
- Enforces in-order responses and rejects misaligned fetches locally with an error response.
- Supports a pipeline flush that discards responses to requests already in flight.
- The MR1 response port has no backpressure, so every response is delivered the cycle it is presented.

---
 rtl/mr1_ibus_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mr1_ibus_bridge.sv
// MR1 instruction-fetch bridge: in-order tag queue, local misalignment errors, flush with response drop.
// Optional response watchdog enabled by defining MR1_IBUS_TIMEOUT_EN.
module mr1_ibus_bridge #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,
    output logic        instr_rsp_error,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_cmd_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("mr1_ibus_bridge: DEPTH must be a power of two in 2..8 and TIMEOUT >= 1");
    end

    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d, drop_q, drop_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_error_q, rsp_error_d;
    logic [31:0]      rsp_data_q, rsp_data_d;

    logic             aligned, space, push, pop;
    logic             head_valid, head_tag;
    logic             drop_dec, drop_inc, tmo_fire, rsp_illegal;
    logic [CW-1:0]    mem_pending;

    assign aligned    = (instr_req_addr[1:0] == 2'b00);
    assign space      = (SW'(count_q) + SW'(drop_q)) < SW'(DEPTH);
    assign head_valid = (count_q != '0);
    assign head_tag   = tag_q[rd_ptr_q];

    assign mem_cmd_valid   = instr_req_valid & aligned & space & ~flush;
    assign mem_cmd_addr    = instr_req_addr;
    assign instr_req_ready = aligned ? (mem_cmd_valid & mem_cmd_ready) : (space & ~flush);
    assign push            = instr_req_valid & instr_req_ready;

    assign rsp_illegal = mem_rsp_valid & (drop_q == '0) & (~head_valid | head_tag);

    // Memory-bound entries still queued; these become drops on flush.
    always_comb begin
        mem_pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && !tag_q[PW'(rd_ptr_q + PW'(i))]) begin
                mem_pending = mem_pending + CW'(1);
            end
        end
    end

`ifdef MR1_IBUS_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_run;

    assign tmo_run  = head_valid & ~head_tag & (drop_q == '0) & ~mem_rsp_valid & ~flush;
    assign tmo_fire = tmo_run & (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (flush || pop) begin
            tmo_d = '0;
        end else if (tmo_run) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Response selection; drops are older than anything queued, so they win over the head.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        pop         = 1'b0;
        drop_dec    = 1'b0;
        drop_inc    = 1'b0;
        if (!flush) begin
            if (mem_rsp_valid && drop_q != '0) begin
                drop_dec = 1'b1;
            end else if (mem_rsp_valid && head_valid && !head_tag) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rsp_data;
                rsp_error_d = mem_rsp_error;
                pop         = 1'b1;
            end
            if (head_valid && head_tag) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_error_d = 1'b1;
                pop         = 1'b1;
            end else if (tmo_fire) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_error_d = 1'b1;
                pop         = 1'b1;
                drop_inc    = 1'b1;
            end
        end
    end

    // Queue and drop bookkeeping.
    always_comb begin
        tag_d    = tag_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drop_d   = drop_q + mem_pending
                     - CW'(mem_rsp_valid && (drop_q != '0 || mem_pending != '0));
        end else begin
            if (push) begin
                tag_d[wr_ptr_q] = ~aligned;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (drop_dec) begin
                drop_d = drop_q - CW'(1);
            end else if (drop_inc) begin
                drop_d = drop_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign instr_rsp_valid = rsp_valid_q;
    assign instr_rsp_data  = rsp_data_q;
    assign instr_rsp_error = rsp_error_q;

    // A memory response with nothing to match it is a protocol violation by the memory side.
    assert property (@(posedge clk) disable iff (!reset_n) !rsp_illegal);

endmodule
